// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake, bubble
// compression, occupancy count and synchronous flush. Optional stall counter: ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_reg #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
`ifdef ELASTIC_PIPE_STALL_CNT_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic [CNT_W-1:0]       count
);

  logic [DEPTH-1:0]       v;
  logic [WORD_LENGTH-1:0] d [DEPTH];
  logic [DEPTH-1:0]       rdy;
  logic [DEPTH-1:0]       vin;
  logic [WORD_LENGTH-1:0] din [DEPTH];
  logic                   in_xfer;
  logic                   out_xfer;

  // rdy[i] is true when any stage at or after i is empty, or the output drains;
  // computed with a running accumulator to avoid a self-referencing vector.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~clr;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    vin    = '0;
    vin[0] = in_xfer;
    din[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = v[i-1];
      din[i] = d[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr)         v[i] <= 1'b0;
        else if (rdy[i]) v[i] <= vin[i];
        if (rdy[i] && vin[i]) d[i] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else          count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  // Saturating count of edges where a valid word is held back by downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       stall_cnt <= '0;
    else if (clr)                                  stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg (WORD_LENGTH=8, DEPTH=3): directed
// steps plus random traffic against a queue-of-words reference model.
module tb_elastic_pipe_reg;
  localparam int WL = 8;
  localparam int DP = 3;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  logic [CW-1:0] count;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  int            m_stall;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: words in flight, oldest first, with their stage position.
  int            qpos[$];
  logic [WL-1:0] qdat[$];

  elastic_pipe_reg #(.WORD_LENGTH(WL), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic m_out_valid();
    return (qpos.size() > 0) && (qpos[0] == DP - 1);
  endfunction

  function automatic logic m_in_ready();
    return !clr && ((qpos.size() < DP) || out_ready);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("in_ready", 16'(in_ready), 16'(m_in_ready()));
    chk("out_valid", 16'(out_valid), 16'(m_out_valid()));
    chk("count", 16'(count), 16'(qpos.size()));
    if (m_out_valid()) chk("out_data", 16'(out_data), 16'(qdat[0]));
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'(m_stall));
`endif
  endtask

  task automatic applyStimulus(input logic iv, input logic [WL-1:0] id,
                               input logic ordy, input logic c);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = c;
    #1;
    checkOutput();
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic clockEdge();
    logic inx, outx;
    int   lim, np;
    @(posedge clk);
    inx  = in_valid && m_in_ready();
    outx = m_out_valid() && out_ready;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    if (clr) m_stall = 0;
    else if (m_out_valid() && !out_ready && m_stall < 65535) m_stall++;
`endif
    if (clr) begin
      qpos.delete();
      qdat.delete();
    end else begin
      if (outx) begin
        void'(qpos.pop_front());
        void'(qdat.pop_front());
      end
      lim = DP - 1;
      for (int k = 0; k < qpos.size(); k++) begin
        np = (qpos[k] + 1 < lim) ? qpos[k] + 1 : lim;
        qpos[k] = np;
        lim = np - 1;
      end
      if (inx) begin
        qpos.push_back(0);
        qdat.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic step(input logic iv, input logic [WL-1:0] id, input logic ordy, input logic c);
    applyStimulus(iv, id, ordy, c);
    clockEdge();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    m_stall = 0;
`endif
    #12 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'h00);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);

    $display("[TB] streaming latency");
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_first_valid", 16'(out_valid), 16'd1);
    chk("lat_first_data", 16'(out_data), 16'h11);
    clockEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_second_data", 16'(out_data), 16'h22);
    clockEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_third_data", 16'(out_data), 16'h33);
    clockEdge();
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] back-pressure");
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("full_in_ready", 16'(in_ready), 16'd0);
    chk("full_count", 16'(count), 16'd3);
    clockEdge();
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("full_pass_in_ready", 16'(in_ready), 16'd1);
    chk("full_pass_data", 16'(out_data), 16'hA1);
    clockEdge();
    chk("full_pass_count", 16'(count), 16'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] flush");
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b1, 1'b1);
    chk("clr_in_ready", 16'(in_ready), 16'd0);
    clockEdge();
    chk("clr_count", 16'(count), 16'd0);
    chk("clr_out_valid", 16'(out_valid), 16'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] async reset mid-stream");
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_count", 16'(count), 16'd0);
    qpos.delete();
    qdat.delete();
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    m_stall = 0;
`endif
    #1 rst = 1'b0;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    $display("[TB] stall counter");
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'hD1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall_ten", stall_cnt, 16'd10);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_clr", stall_cnt, 16'd0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
